// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// the lane/extension helpers used by both the datapath and the IO port.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        IO_WAIT = 2'd2,
        RESP    = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    // Anything that is not a byte or halfword access behaves as a word.
    function automatic lsu_size_e access_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr);
        case (access_size(funct3))
            SZ_B:    return 1'b0;
            SZ_H:    return addr[0];
            default: return addr != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] funct3, input logic [1:0] addr);
        case (access_size(funct3))
            SZ_B:    return 4'b0001 << addr;
            SZ_H:    return addr[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] wdata);
        case (access_size(funct3))
            SZ_B:    return {4{wdata[7:0]}};
            SZ_H:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] funct3, input logic [1:0] addr,
                                                input logic [31:0] word);
        logic [15:0] half;
        logic [7:0]  byte_v;
        half   = addr[1] ? word[31:16] : word[15:0];
        byte_v = addr[0] ? half[15:8] : half[7:0];
        case (funct3)
            F3_B:    return {{24{byte_v[7]}}, byte_v};
            F3_BU:   return {24'b0, byte_v};
            F3_H:    return {{16{half[15]}}, half};
            F3_HU:   return {16'b0, half};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ram.sv
// Single-port data RAM with per-byte write enables and a registered read port.
module lsu_ram
    import lsu_pkg::*;
#(
    parameter int RAM_WORDS = 16384
) (
    input  logic                         clk,
    input  logic                         re,
    input  logic [3:0]                   we,
    input  logic [$clog2(RAM_WORDS)-1:0] addr,
    input  logic [31:0]                  wdata,
    output logic [31:0]                  rdata
);

    logic [31:0] mem [RAM_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
        if (re) rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/lsu_mem.sv
// Load/store unit: one request at a time, byte-masked data RAM plus a
// memory-mapped IO port with wait states and a timeout.
module lsu_mem
    import lsu_pkg::*;
#(
    parameter int RAM_WORDS  = 16384,
    parameter int IO_BIT     = 22,
    parameter int IO_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic        rsp_err,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    output logic [3:0]  io_wstrb,
    output logic        io_wr,
    output logic        io_rd,
    input  logic [31:0] io_rdata,
    input  logic        io_ready
);

    localparam int          AW      = $clog2(RAM_WORDS);
    localparam logic [15:0] TIMEOUT = 16'(IO_TIMEOUT);

    lsu_state_e  state_q, state_d;
    logic        store_q, store_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic        err_q, err_d;
    logic [31:0] iodata_q, iodata_d;
    logic [15:0] cnt_q, cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [4:0]  rsp_rd_q, rsp_rd_d;
    logic        rsp_err_q, rsp_err_d;

    logic [3:0]  ram_we;
    logic        ram_re;
    logic [31:0] ram_rdata;
    logic [3:0]  mask;
    logic [31:0] lanes;
    logic        io_active;

    assign mask      = store_mask(f3_q, addr_q[1:0]);
    assign lanes     = store_lanes(f3_q, wdata_q);
    assign io_active = (state_q == IO_WAIT);

    lsu_ram #(.RAM_WORDS(RAM_WORDS)) u_ram (
        .clk   (clk),
        .re    (ram_re),
        .we    (ram_we),
        .addr  (addr_q[AW+1:2]),
        .wdata (lanes),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        err_d       = err_q;
        iodata_d    = iodata_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        rsp_rd_d    = '0;
        rsp_err_d   = 1'b0;
        ram_we      = 4'b0;
        ram_re      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    store_d = req_store;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rd_d    = req_rd;
                    err_d   = misaligned(req_funct3, req_addr[1:0]);
                    cnt_d   = '0;
                    if (err_d)              state_d = RESP;
                    else if (req_addr[IO_BIT]) state_d = IO_WAIT;
                    else                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                ram_we  = store_q ? mask : 4'b0;
                ram_re  = !store_q;
                state_d = RESP;
            end
            IO_WAIT: begin
                if (io_ready) begin
                    iodata_d = io_rdata;
                    state_d  = RESP;
                end else if (cnt_q >= TIMEOUT) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                // Response fields are registered, so they appear the cycle after RESP.
                rsp_valid_d = 1'b1;
                rsp_err_d   = err_q;
                if (!err_q && !store_q) begin
                    rsp_data_d = load_extend(f3_q, addr_q[1:0], addr_q[IO_BIT] ? iodata_q : ram_rdata);
                    rsp_rd_d   = rd_q;
                end
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            store_q     <= 1'b0;
            f3_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            err_q       <= 1'b0;
            iodata_q    <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_rd_q    <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            err_q       <= err_d;
            iodata_q    <= iodata_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_rd    = rsp_rd_q;
    assign rsp_err   = rsp_err_q;
    assign io_addr   = io_active ? addr_q : 32'b0;
    assign io_wdata  = (io_active && store_q) ? lanes : 32'b0;
    assign io_wstrb  = (io_active && store_q) ? mask : 4'b0;
    assign io_wr     = io_active && store_q;
    assign io_rd     = io_active && !store_q;

endmodule

// File: tb/tb_lsu_mem.sv
// Bench for lsu_mem: byte-array reference model, randomized RAM/IO traffic,
// then the directed scenarios (store/load lanes, misalignment, IO waits, reset).
module tb_lsu_mem;

    localparam int RAM_WORDS  = 256;
    localparam int IO_BIT     = 22;
    localparam int IO_TIMEOUT = 4;
    localparam int NBYTES     = RAM_WORDS * 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_store = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic [31:0] io_addr, io_wdata;
    logic [3:0]  io_wstrb;
    logic        io_wr, io_rd;
    logic [31:0] io_rdata = '0;
    logic        io_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [7:0] mem_m [NBYTES];

    lsu_mem #(.RAM_WORDS(RAM_WORDS), .IO_BIT(IO_BIT), .IO_TIMEOUT(IO_TIMEOUT)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_wstrb(io_wstrb), .io_wr(io_wr), .io_rd(io_rd),
        .io_rdata(io_rdata), .io_ready(io_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int sz_of(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] word);
        int     sz  = sz_of(f3);
        int     off = int'(addr[1:0]);
        longint v;
        v = (longint'(word) >> (8 * off)) & ((64'd1 << (8 * sz)) - 1);
        if ((f3 == 3'd0 || f3 == 3'd1) && v[8*sz-1]) v = v - (64'sd1 <<< (8 * sz));
        return v[31:0];
    endfunction

    function automatic logic [31:0] ram_word(input logic [31:0] addr);
        int base = int'(addr % 32'(NBYTES)) & ~3;
        return {mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]};
    endfunction

    // ---------------- one transaction ----------------
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd, input int io_delay,
                          input logic [31:0] io_val, output logic [31:0] o_data);
        int sz = sz_of(f3);
        bit is_io = addr[IO_BIT];
        bit mis = (int'(addr[1:0]) % sz) != 0;
        bit tmo = is_io && !mis && (io_delay < 0 || io_delay > IO_TIMEOUT);
        logic [31:0] lanes;
        logic [3:0]  mask;
        int exp_strb, exp_lat, strb, lat, k;
        bit got;
        logic [31:0] exp_data;
        logic [4:0]  o_rd;
        logic        o_err;
        for (int j = 0; j < 4; j++) lanes[8*j +: 8] = wd[8*(j % sz) +: 8];
        mask = 4'(((1 << sz) - 1) << addr[1:0]);
        exp_strb = (!is_io || mis) ? 0 : (tmo ? IO_TIMEOUT + 1 : io_delay + 1);
        exp_lat  = mis ? 1 : (is_io ? exp_strb + 1 : 2);
        exp_data = 32'b0;
        if (!st && !mis && !tmo) exp_data = extract(f3, addr, is_io ? io_val : ram_word(addr));

        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr;
        req_wdata = wd; req_rd = rd;
        k = 0;
        while (!req_ready && k < 20) begin @(negedge clk); k++; end
        chk("req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_store = $urandom; req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
        strb = 0; got = 0; lat = -1; o_data = '0; o_rd = '0; o_err = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1; lat = c; o_data = rsp_data; o_rd = rsp_rd; o_err = rsp_err;
            end
            if (io_wr || io_rd) begin
                chk("io_addr", io_addr, addr);
                chk("io_dir", {io_wr, io_rd}, st ? 32'd2 : 32'd1);
                if (st) begin
                    chk("io_wdata", io_wdata, lanes);
                    chk("io_wstrb", 32'(io_wstrb), 32'(mask));
                end
                if (io_delay >= 0 && strb == io_delay) begin
                    io_ready = 1'b1; io_rdata = io_val;
                end else begin
                    io_ready = 1'b0; io_rdata = $urandom;
                end
                strb++;
            end else begin
                io_ready = 1'b0;
            end
        end
        io_ready = 1'b0;
        chk("rsp_seen", 32'(got), 32'd1);
        chk("rsp_latency", 32'(lat), 32'(exp_lat));
        chk("io_strobe_cycles", 32'(strb), 32'(exp_strb));
        chk("rsp_err", 32'(o_err), 32'(mis || tmo));
        chk("rsp_data", o_data, exp_data);
        chk("rsp_rd", 32'(o_rd), (!st && !mis && !tmo) ? 32'(rd) : 32'd0);
        @(negedge clk);
        chk("rsp_pulse", {rsp_valid, rsp_err, rsp_rd, rsp_data[24:0]}, 32'd0);
        chk("io_idle", {io_wr, io_rd, io_wstrb}, 32'd0);
        if (st && !is_io && !mis) begin
            int idx = int'(addr % 32'(NBYTES));
            for (int i = 0; i < sz; i++) mem_m[idx+i] = wd[8*i +: 8];
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d, a;
        logic [2:0]  f3s [8];
        logic [2:0]  f3;
        bit          st, io;
        f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd3};

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rd}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_io", {io_wr, io_rd, io_wstrb}, 32'd0);
        chk("rst_io_addr", io_addr | io_wdata, 32'd0);
        resetn = 1'b1;

        // Fill every word so the model and RAM agree everywhere.
        for (int i = 0; i < RAM_WORDS; i++) begin
            a = ($urandom & ~(32'd1 << IO_BIT) & ~32'(NBYTES - 1)) | 32'(i * 4);
            run_op(1'b1, 3'd2, a, $urandom, 5'($urandom), -1, 32'd0, d);
        end

        // Randomized mix: aliasing upper address bits, all funct3 codes, IO waits/timeouts.
        for (int n = 0; n < 200; n++) begin
            st = $urandom_range(0, 1);
            io = ($urandom_range(0, 4) == 0);
            f3 = f3s[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(6, 7));
            a = $urandom;
            a[IO_BIT] = io;
            run_op(st, f3, a, $urandom, 5'($urandom), $urandom_range(0, IO_TIMEOUT + 2) - 1,
                   $urandom, d);
        end

        // Word store / load round trip.
        run_op(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 5'd3, -1, 32'd0, d);
        run_op(1'b0, 3'd2, 32'h100, 32'd0, 5'd9, -1, 32'd0, d);
        chk("lw_deadbeef", d, 32'hDEADBEEF);

        // Byte store into a zero word and the three load flavours.
        run_op(1'b1, 3'd2, 32'h100, 32'h0, 5'd0, -1, 32'd0, d);
        run_op(1'b1, 3'd0, 32'h103, 32'h80, 5'd0, -1, 32'd0, d);
        run_op(1'b0, 3'd0, 32'h103, 32'd0, 5'd5, -1, 32'd0, d);
        chk("lb_signext", d, 32'hFFFFFF80);
        run_op(1'b0, 3'd4, 32'h103, 32'd0, 5'd6, -1, 32'd0, d);
        chk("lbu_zeroext", d, 32'h00000080);
        run_op(1'b0, 3'd2, 32'h100, 32'd0, 5'd7, -1, 32'd0, d);
        chk("lw_after_sb", d, 32'h80000000);

        // Misaligned accesses leave RAM untouched.
        run_op(1'b0, 3'd1, 32'h101, 32'd0, 5'd8, -1, 32'd0, d);
        run_op(1'b1, 3'd2, 32'h102, 32'h11111111, 5'd0, -1, 32'd0, d);
        run_op(1'b0, 3'd2, 32'h100, 32'd0, 5'd7, -1, 32'd0, d);
        chk("lw_after_misaligned", d, 32'h80000000);

        // IO: three wait cycles, timeout on a halfword store, zero-wait load.
        run_op(1'b0, 3'd2, 32'h0040_0004, 32'd0, 5'd12, 3, 32'h12345678, d);
        chk("io_load_data", d, 32'h12345678);
        run_op(1'b1, 3'd1, 32'h0040_0006, 32'hABCD1234, 5'd0, -1, 32'd0, d);
        run_op(1'b0, 3'd5, 32'h0040_0002, 32'd0, 5'd13, 0, 32'h8765_4321, d);
        chk("io_zero_wait_hu", d, 32'h00008765);

        // Reset while the IO read is pending.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0040_0010; req_rd = 5'd4;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("io_rd_pending", 32'(io_rd), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("rst_mid_io", {io_rd, io_wr, rsp_valid}, 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_rsp_after_reset", {rsp_valid, io_rd}, 32'd0);
        end
        run_op(1'b0, 3'd2, 32'h100, 32'd0, 5'd21, -1, 32'd0, d);
        chk("lw_after_reset", d, 32'h80000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
